// File: rtl/lsu_mem_access.sv
// Load/store unit memory access sequencer: accepts one load/store at a time,
// drives a single-beat memory request and hands the result to writeback.
module lsu_mem_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_zero_ext,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_is_nop,
    output logic        wb_is_load,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_size,
    output logic        wb_zero_ext,
    output logic        lsu_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(ACK_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          cap_is_load;
    logic [4:0]    cap_rd;
    logic [1:0]    cap_size;
    logic          cap_zero_ext;
    logic [1:0]    cap_off;

    logic          req_illegal;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   rdata_shifted;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    assign req_ready = (state == IDLE);

    always_comb begin
        req_illegal = 1'b0;
        be_next     = 4'b0000;
        wdata_next  = 32'h0;
        case (req_size)
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_illegal = req_addr[0];
                be_next     = 4'b0011 << req_addr[1:0];
                wdata_next  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                req_illegal = (req_addr[1:0] != 2'b00) || req_zero_ext;
                be_next     = 4'b1111;
                wdata_next  = req_wdata;
            end
            default: req_illegal = 1'b1;
        endcase
    end

    assign rdata_shifted = mem_rdata >> {cap_off, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            cap_is_load  <= 1'b0;
            cap_rd       <= 5'd0;
            cap_size     <= 2'd0;
            cap_zero_ext <= 1'b0;
            cap_off      <= 2'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_be       <= 4'b0000;
            mem_wdata    <= 32'h0;
            wb_is_nop    <= 1'b1;
            wb_is_load   <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0;
            wb_size      <= 2'd0;
            wb_zero_ext  <= 1'b0;
            lsu_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_is_load  <= req_is_load;
                        cap_rd       <= req_rd;
                        cap_size     <= req_size;
                        cap_zero_ext <= req_zero_ext;
                        cap_off      <= req_addr[1:0];
                        if (req_illegal) begin
                            // Illegal requests never reach memory.
                            state     <= RESP;
                            lsu_err   <= 1'b1;
                            wb_is_nop <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= !req_is_load;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack || wait_cnt == LAST_WAIT) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                    // An ack in the final wait cycle still wins over the timeout.
                    if (mem_ack) begin
                        wb_is_nop   <= 1'b0;
                        wb_is_load  <= cap_is_load;
                        wb_rd       <= cap_rd;
                        wb_size     <= cap_size;
                        wb_zero_ext <= cap_zero_ext;
                        wb_data     <= cap_is_load ? rdata_shifted : 32'h0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        wb_is_nop <= 1'b1;
                        lsu_err   <= 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    wb_is_nop   <= 1'b1;
                    wb_is_load  <= 1'b0;
                    wb_rd       <= 5'd0;
                    wb_data     <= 32'h0;
                    wb_size     <= 2'd0;
                    wb_zero_ext <= 1'b0;
                    lsu_err     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed corner transactions plus randomized
// loads/stores checked against a lane-arithmetic reference model.
module tb_lsu_mem_access;

    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic [4:0]  req_rd;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_zero_ext;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_is_nop;
    logic        wb_is_load;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_size;
    logic        wb_zero_ext;
    logic        lsu_err;

    int n_vec = 0;
    int n_err = 0;

    lsu_mem_access #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_rd(req_rd), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_zero_ext(req_zero_ext),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_is_nop(wb_is_nop), .wb_is_load(wb_is_load), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_size(wb_size), .wb_zero_ext(wb_zero_ext),
        .lsu_err(lsu_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet_wb(input string tag);
        check_eq({tag, "_err"},    32'(lsu_err), 32'd0);
        check_eq({tag, "_nop"},    32'(wb_is_nop), 32'd1);
        check_eq({tag, "_isld"},   32'(wb_is_load), 32'd0);
        check_eq({tag, "_rd"},     32'(wb_rd), 32'd0);
        check_eq({tag, "_data"},   wb_data, 32'd0);
        check_eq({tag, "_size"},   32'(wb_size), 32'd0);
        check_eq({tag, "_zext"},   32'(wb_zero_ext), 32'd0);
    endtask

    // One complete transaction starting from IDLE; ack_delay counts ACCESS
    // cycles (1 = ack in the first one), values above ACK_TIMEOUT mean no ack.
    task automatic do_txn(input bit is_load, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input bit zext,
                          input logic [31:0] rdata, input int ack_delay, input bit stray);
        int nb, off;
        bit illegal, err, acked;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_data;
        off = int'(addr[1:0]);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        illegal = (size == 2'd3) || ((off % nb) != 0) || (zext && size == 2'd2);
        exp_be = 4'(((1 << nb) - 1) << off);
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*(j % nb) +: 8];
        exp_data = rdata >> (8 * off);

        @(negedge clk);
        check_eq("ready_in_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_is_load = is_load; req_rd = rd; req_addr = addr;
        req_wdata = wdata; req_size = size; req_zero_ext = zext;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_rd = 5'($urandom); req_size = 2'($urandom); req_is_load = 1'($urandom);
        err = illegal;
        acked = 1'b0;
        if (!illegal) begin
            for (int i = 1; i <= ACK_TIMEOUT && !acked; i++) begin
                check_eq("acc_req",   32'(mem_req), 32'd1);
                check_eq("acc_we",    32'(mem_we), 32'(!is_load));
                check_eq("acc_addr",  mem_addr, addr & 32'hFFFF_FFFC);
                check_eq("acc_be",    32'(mem_be), 32'(exp_be));
                check_eq("acc_wdata", mem_wdata, exp_wd);
                check_eq("acc_ready", 32'(req_ready), 32'd0);
                check_eq("acc_nop",   32'(wb_is_nop), 32'd1);
                if (i == ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = rdata; acked = 1'b1;
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
            err = !acked;
        end
        check_eq("resp_req",   32'(mem_req), 32'd0);
        check_eq("resp_ready", 32'(req_ready), 32'd0);
        check_eq("resp_err",   32'(lsu_err), 32'(err));
        check_eq("resp_nop",   32'(wb_is_nop), 32'(err));
        check_eq("resp_isld",  32'(wb_is_load), 32'(!err && is_load));
        if (!err) begin
            check_eq("resp_rd",   32'(wb_rd), 32'(rd));
            check_eq("resp_size", 32'(wb_size), 32'(size));
            check_eq("resp_zext", 32'(wb_zero_ext), 32'(zext));
            check_eq("resp_data", wb_data, is_load ? exp_data : 32'd0);
        end
        if (stray) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("post_ready", 32'(req_ready), 32'd1);
        check_eq("post_req",   32'(mem_req), 32'd0);
        check_quiet_wb("post");
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int dly;
        rst_n = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_rd = 5'd0;
        req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'd0; req_zero_ext = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_req",   32'(mem_req), 32'd0);
        check_eq("rst_we",    32'(mem_we), 32'd0);
        check_eq("rst_addr",  mem_addr, 32'd0);
        check_eq("rst_be",    32'(mem_be), 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_quiet_wb("rst");
        rst_n = 1'b1;

        // Directed corners: LB high lane, SH upper half, misaligned LW, timeout, last-cycle ack.
        do_txn(1'b1, 5'd3, 32'h0000_1003, 32'h0, 2'd0, 1'b0, 32'hAB00_0000, 2, 1'b0);
        do_txn(1'b0, 5'd4, 32'h0000_2002, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0, 1, 1'b1);
        do_txn(1'b1, 5'd5, 32'h0000_3001, 32'h0, 2'd2, 1'b0, 32'h0, 1, 1'b0);
        do_txn(1'b1, 5'd6, 32'h0000_4000, 32'h0, 2'd2, 1'b0, 32'h1234_5678, ACK_TIMEOUT + 1, 1'b0);
        do_txn(1'b1, 5'd7, 32'h0000_4000, 32'h0, 2'd2, 1'b0, 32'h8765_4321, ACK_TIMEOUT, 1'b0);
        do_txn(1'b1, 5'd8, 32'h0000_5000, 32'h0, 2'd2, 1'b1, 32'h0, 1, 1'b0);
        do_txn(1'b1, 5'd9, 32'h0000_5002, 32'h0, 2'd3, 1'b0, 32'h0, 1, 1'b0);

        // Reset in the middle of ACCESS, then a late ack.
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b1; req_addr = 32'h0000_6000; req_size = 2'd2;
        req_zero_ext = 1'b0; req_rd = 5'd10;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rstacc_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstacc_req_async",   32'(mem_req), 32'd0);
        check_eq("rstacc_ready_async", 32'(req_ready), 32'd1);
        check_eq("rstacc_be_async",    32'(mem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("rstacc_req_after",   32'(mem_req), 32'd0);
        check_eq("rstacc_ready_after", 32'(req_ready), 32'd1);
        check_quiet_wb("rstacc_a");
        @(negedge clk);
        check_quiet_wb("rstacc_b");

        // req_valid held across two requests: second waits for IDLE after RESP.
        req_valid = 1'b1; req_is_load = 1'b0; req_addr = 32'h0000_7000; req_size = 2'd2;
        req_wdata = 32'h1111_2222; req_rd = 5'd11;
        @(negedge clk);
        check_eq("b2b_first_req",  32'(mem_req), 32'd1);
        check_eq("b2b_first_addr", mem_addr, 32'h0000_7000);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("b2b_resp_ready", 32'(req_ready), 32'd0);
        check_eq("b2b_resp_nop",   32'(wb_is_nop), 32'd0);
        req_addr = 32'h0000_8004;
        @(negedge clk);
        check_eq("b2b_idle_ready", 32'(req_ready), 32'd1);
        check_eq("b2b_idle_req",   32'(mem_req), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("b2b_second_req",  32'(mem_req), 32'd1);
        check_eq("b2b_second_addr", mem_addr, 32'h0000_8004);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("b2b_second_resp", 32'(wb_is_nop), 32'd0);
        @(negedge clk);

        // Randomized traffic; mostly legal sizes with occasional timeouts.
        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            dly = ($urandom_range(0, 9) == 0) ? ACK_TIMEOUT + 1 : $urandom_range(1, ACK_TIMEOUT);
            do_txn(1'($urandom), 5'($urandom), a, $urandom, sz,
                   ($urandom_range(0, 4) == 0), $urandom, dly, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
